// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants, types and the hex segment table for the 4-digit
// multiplexed seven-segment scan driver.
package seven_seg_scan_driver_pkg;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  // Active-low gfedcba patterns, indexed by hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Per-slot copy of the inputs that belong to the digit being shown.
  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
    logic [2:0] bright;
  } snap_t;

  localparam snap_t SNAP_RESET = '{value: 4'h0, dp: 1'b0, blank: 1'b1, bright: 3'd0};

  function automatic logic [3:0] anode_onehot_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display bus: digit data, per-digit controls and the multiplexed
// anode/segment outputs plus the frame tick.
interface seven_seg_scan_driver_if;
  // No handshake: every input is a level that the driver samples only at
  // slot boundaries; outputs are registered levels plus a one-clock tick.
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] in3;
  logic [3:0] dp_in;
  logic [3:0] blank;
  logic [2:0] brightness;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  modport master (
    output in0, in1, in2, in3, dp_in, blank, brightness,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  in0, in1, in2, in3, dp_in, blank, brightness,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan_driver_hex_to_sseg.sv
// Combinational hex digit to active-low gfedcba segment decode.
module hex_to_sseg
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-slot input
// snapshot, PWM brightness, blanking and a once-per-frame tick.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_seg_scan_driver_if.slave  bus,
  output scan_state_e             state_o
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam int            SLOT8    = DIV / 8;

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  snap_t         snap_q, snap_d;
  snap_t         cap;
  logic          slot_start;

  logic [3:0]    an_q, an_d;
  logic [7:0]    sseg_q, sseg_d;
  logic          tick_q, tick_d;

  logic [6:0]    seg_w;
  logic [31:0]   on_lim;
  logic          lit;

  // IDLE exists only so the first edge after reset opens slot 0 with a
  // fresh snapshot instead of counting from the reset value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    slot_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d    = ST_SCAN;
        cnt_d      = '0;
        idx_d      = 2'd0;
        slot_start = 1'b1;
      end
      ST_SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          idx_d      = idx_q + 2'd1;
          slot_start = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cap        = SNAP_RESET;
    unique case (idx_d)
      2'd0:    cap.value = bus.in0;
      2'd1:    cap.value = bus.in1;
      2'd2:    cap.value = bus.in2;
      default: cap.value = bus.in3;
    endcase
    cap.dp     = bus.dp_in[idx_d];
    cap.blank  = bus.blank[idx_d];
    cap.bright = bus.brightness;
  end

  always_comb begin
    snap_d = snap_q;
    if (slot_start) begin
      snap_d = cap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= SNAP_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  hex_to_sseg u_hex_to_sseg (
    .hex_i (snap_q.value),
    .seg_o (seg_w)
  );

  // Outputs are registered from the current slot state, so they trail it
  // by one clock; at full brightness the on-window covers the whole slot.
  always_comb begin
    on_lim = (32'(snap_q.bright) + 32'd1) * 32'(SLOT8);
    lit    = (state_q == ST_SCAN) && !snap_q.blank && (32'(cnt_q) < on_lim);
    an_d   = AN_OFF;
    sseg_d = SEG_OFF;
    if (lit) begin
      an_d   = anode_onehot_n(idx_q);
      sseg_d = {~snap_q.dp, seg_w};
    end
    tick_d = (state_q == ST_SCAN) && (idx_q == 2'd3) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q   <= AN_OFF;
      sseg_q <= SEG_OFF;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
      tick_q <= tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = tick_q;
  assign state_o        = state_q;

  a_tick_single: assert property (@(posedge clk) disable iff (reset) tick_q |=> !tick_q);
  a_one_anode:   assert property (@(posedge clk) disable iff (reset) $countones(~an_q) <= 1);
  a_dark_segs:   assert property (@(posedge clk) disable iff (reset) (an_q == AN_OFF) |-> (sseg_q == SEG_OFF));

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver at DIV=8 against a
// slot/phase arithmetic reference model.
module tb_seven_seg_scan_driver;
  import seven_seg_scan_driver_pkg::*;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset;
  scan_state_e dbg_state;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if ifc ();

  seven_seg_scan_driver #(.DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (ifc.slave),
    .state_o (dbg_state)
  );

  // Reference segment patterns (gfedcba, active-low).
  logic [6:0] ref_seg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] val;
    logic       dp;
    logic       blank;
    logic [2:0] br;
  } rec_t;

  // tclk = rising edges since reset release; slot n opens at edge n*DIV+1.
  int   tclk = 0;
  rec_t slot_q[$];
  rec_t mon_r;
  int   mon_d;

  always @(posedge clk) begin
    if (reset) begin
      tclk = 0;
      slot_q.delete();
    end else begin
      tclk++;
      if ((tclk - 1) % DIV == 0) begin
        mon_d = ((tclk - 1) / DIV) % 4;
        case (mon_d)
          0:       mon_r.val = ifc.in0;
          1:       mon_r.val = ifc.in1;
          2:       mon_r.val = ifc.in2;
          default: mon_r.val = ifc.in3;
        endcase
        mon_r.dp    = ifc.dp_in[mon_d];
        mon_r.blank = ifc.blank[mon_d];
        mon_r.br    = ifc.brightness;
        slot_q.push_back(mon_r);
      end
    end
  end

  // Outputs after edge tclk show the scan position one clock earlier.
  function automatic void model(output logic [3:0] e_an, output logic [7:0] e_sg,
                                output logic e_ft);
    int s, slot, digit, phase;
    rec_t r;
    e_an = 4'b1111;
    e_sg = 8'hFF;
    e_ft = 1'b0;
    if (tclk >= 2) begin
      s     = tclk - 2;
      slot  = s / DIV;
      digit = slot % 4;
      phase = s % DIV;
      e_ft  = (s % (4 * DIV)) == (4 * DIV - 1);
      if (slot < slot_q.size()) begin
        r = slot_q[slot];
        if (!r.blank && phase < (int'(r.br) + 1) * (DIV / 8)) begin
          e_an = 4'b1111;
          e_an[digit] = 1'b0;
          e_sg = {~r.dp, ref_seg[r.val]};
        end
      end
    end
  endfunction

  task automatic set_inputs(input logic [3:0] v3, input logic [3:0] v2, input logic [3:0] v1,
                            input logic [3:0] v0, input logic [3:0] dp, input logic [3:0] bl,
                            input logic [2:0] br);
    ifc.in3 = v3; ifc.in2 = v2; ifc.in1 = v1; ifc.in0 = v0;
    ifc.dp_in = dp; ifc.blank = bl; ifc.brightness = br;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    set_inputs(4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 3'd7);
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ifc.an !== 4'b1111 || ifc.sseg !== 8'hFF || ifc.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_async an=%b sseg=%h ft=%b want 1111/ff/0", ifc.an, ifc.sseg, ifc.frame_tick);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ifc.an !== 4'b1111 || ifc.sseg !== 8'hFF || ifc.frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold an=%b sseg=%h ft=%b want 1111/ff/0", ifc.an, ifc.sseg, ifc.frame_tick);
      end
    end
    reset = 1'b0;
    // First edge only opens slot 0; the registered outputs stay dark.
    @(negedge clk);
    model(e_an, e_sg, e_ft);
    checks++;
    if (ifc.an !== e_an || ifc.sseg !== e_sg || ifc.frame_tick !== e_ft) begin
      errors++;
      $display("FAIL reset_first_edge an=%b sseg=%h ft=%b want %b/%h/%b",
               ifc.an, ifc.sseg, ifc.frame_tick, e_an, e_sg, e_ft);
    end
  endtask

  task automatic test_count_up();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    logic [3:0] spec_an [4];
    logic [7:0] spec_sg [4];
    int d;
    spec_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    spec_sg = '{8'b11000000, 8'b11111001, 8'b10100100, 8'b10110000};
    set_inputs(4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 3'd7);
    apply_reset();
    repeat (2 * 4 * DIV + 2) begin
      @(negedge clk);
      model(e_an, e_sg, e_ft);
      checks++;
      if (ifc.an !== e_an || ifc.sseg !== e_sg || ifc.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL count_up t=%0d an=%b sseg=%h ft=%b want %b/%h/%b",
                 tclk, ifc.an, ifc.sseg, ifc.frame_tick, e_an, e_sg, e_ft);
      end
      if (tclk >= 2 && (tclk - 2) / DIV < 4) begin
        d = (tclk - 2) / DIV;
        checks++;
        if (ifc.an !== spec_an[d] || ifc.sseg !== spec_sg[d]) begin
          errors++;
          $display("FAIL count_up_digit%0d t=%0d an=%b sseg=%b want %b/%b",
                   d, tclk, ifc.an, ifc.sseg, spec_an[d], spec_sg[d]);
        end
      end
    end
  endtask

  task automatic test_pwm();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    int lowcnt = 0;
    set_inputs(4'h7, 4'hA, 4'h5, 4'hE, 4'h0, 4'h0, 3'd1);
    apply_reset();
    repeat (2 * 4 * DIV + 1) begin
      @(negedge clk);
      model(e_an, e_sg, e_ft);
      checks++;
      if (ifc.an !== e_an || ifc.sseg !== e_sg || ifc.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL pwm t=%0d an=%b sseg=%h ft=%b want %b/%h/%b",
                 tclk, ifc.an, ifc.sseg, ifc.frame_tick, e_an, e_sg, e_ft);
      end
      if (tclk >= 2) begin
        if (ifc.an !== 4'b1111) lowcnt++;
        if ((tclk - 2) % DIV == DIV - 1) begin
          checks++;
          if (lowcnt != 2) begin
            errors++;
            $display("FAIL pwm_on_count t=%0d got %0d want 2", tclk, lowcnt);
          end
          lowcnt = 0;
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    int d;
    set_inputs(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'b0001, 4'b0100, 3'd7);
    apply_reset();
    repeat (4 * DIV + 1) begin
      @(negedge clk);
      model(e_an, e_sg, e_ft);
      checks++;
      if (ifc.an !== e_an || ifc.sseg !== e_sg || ifc.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL blank_dp t=%0d an=%b sseg=%h ft=%b want %b/%h/%b",
                 tclk, ifc.an, ifc.sseg, ifc.frame_tick, e_an, e_sg, e_ft);
      end
      if (tclk >= 2) begin
        d = ((tclk - 2) / DIV) % 4;
        if (d == 2) begin
          checks++;
          if (ifc.an !== 4'b1111 || ifc.sseg !== 8'hFF) begin
            errors++;
            $display("FAIL blank_digit2 t=%0d an=%b sseg=%h want 1111/ff", tclk, ifc.an, ifc.sseg);
          end
        end else if (d == 0) begin
          checks++;
          if (ifc.sseg[7] !== 1'b0) begin
            errors++;
            $display("FAIL dp_digit0 t=%0d sseg7=%b want 0", tclk, ifc.sseg[7]);
          end
        end
      end
    end
  endtask

  task automatic test_midslot_change();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    set_inputs(4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 3'd7);
    apply_reset();
    repeat (5 * DIV + 2) begin
      @(negedge clk);
      model(e_an, e_sg, e_ft);
      checks++;
      if (ifc.an !== e_an || ifc.sseg !== e_sg || ifc.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL midslot t=%0d an=%b sseg=%h ft=%b want %b/%h/%b",
                 tclk, ifc.an, ifc.sseg, ifc.frame_tick, e_an, e_sg, e_ft);
      end
      if (tclk >= 2 && tclk < 2 + DIV) begin
        checks++;
        if (ifc.sseg[6:0] !== 7'b1000000) begin
          errors++;
          $display("FAIL midslot_hold t=%0d seg=%b want 1000000", tclk, ifc.sseg[6:0]);
        end
      end
      if (tclk >= 2 + 4 * DIV && tclk < 2 + 5 * DIV) begin
        checks++;
        if (ifc.sseg[6:0] !== 7'b0010000) begin
          errors++;
          $display("FAIL midslot_next t=%0d seg=%b want 0010000", tclk, ifc.sseg[6:0]);
        end
      end
      // Scan sits at cnt=3 of the digit-0 slot here.
      if (tclk == 4) ifc.in0 = 4'h9;
    end
  endtask

  task automatic test_frame_tick();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    int seen[$];
    int want[3];
    want = '{32, 64, 96};
    set_inputs(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 3'd7);
    apply_reset();
    while (tclk < 99) begin
      @(negedge clk);
      model(e_an, e_sg, e_ft);
      checks++;
      if (ifc.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL frame_tick_cycle t=%0d ft=%b want %b", tclk, ifc.frame_tick, e_ft);
      end
      if (ifc.frame_tick === 1'b1) seen.push_back(tclk - 1);
    end
    checks++;
    if (seen.size() != 3) begin
      errors++;
      $display("FAIL frame_tick_count got %0d want 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen[i] != want[i]) begin
          errors++;
          $display("FAIL frame_tick_at%0d got %0d want %0d", i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midslot();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    set_inputs(4'h8, 4'hC, 4'hB, 4'h6, 4'h0, 4'h0, 3'd7);
    apply_reset();
    while (tclk < 2 * DIV + 6) @(negedge clk);
    // Scan is at cnt=5 of digit 2.
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.an !== 4'b1111 || ifc.sseg !== 8'hFF || ifc.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid an=%b sseg=%h ft=%b want 1111/ff/0", ifc.an, ifc.sseg, ifc.frame_tick);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4 * DIV + 2) begin
      @(negedge clk);
      model(e_an, e_sg, e_ft);
      checks++;
      if (ifc.an !== e_an || ifc.sseg !== e_sg || ifc.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL reset_mid_restart t=%0d an=%b sseg=%h ft=%b want %b/%h/%b",
                 tclk, ifc.an, ifc.sseg, ifc.frame_tick, e_an, e_sg, e_ft);
      end
      if (tclk == 2) begin
        checks++;
        if (ifc.an !== 4'b1110 || ifc.sseg !== 8'b10000010) begin
          errors++;
          $display("FAIL reset_mid_digit0 an=%b sseg=%b want 1110/10000010", ifc.an, ifc.sseg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] e_an; logic [7:0] e_sg; logic e_ft;
    set_inputs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom), 3'($urandom));
    apply_reset();
    repeat (400) begin
      @(negedge clk);
      model(e_an, e_sg, e_ft);
      checks++;
      if (ifc.an !== e_an || ifc.sseg !== e_sg || ifc.frame_tick !== e_ft) begin
        errors++;
        $display("FAIL random t=%0d an=%b sseg=%h ft=%b want %b/%h/%b",
                 tclk, ifc.an, ifc.sseg, ifc.frame_tick, e_an, e_sg, e_ft);
      end
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 6))
          0: ifc.in0 = 4'($urandom);
          1: ifc.in1 = 4'($urandom);
          2: ifc.in2 = 4'($urandom);
          3: ifc.in3 = 4'($urandom);
          4: ifc.dp_in = 4'($urandom);
          5: ifc.blank = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
          default: ifc.brightness = 3'($urandom);
        endcase
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_pwm();
    test_blank_dp();
    test_midslot_change();
    test_frame_tick();
    test_reset_midslot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
